// File: rtl/btn_press_counter_pkg.sv
// Shared BCD constants and digit type for the button press counter.
package btn_press_counter_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit.sv
// Combinational single-digit BCD step: +1 with carry out, -1 with borrow out.
module bcd_digit
   import btn_press_counter_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             inc,
   input  logic             dec,
   input  logic             carry_in,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] next,
   output logic             carry_out,
   output logic             borrow_out
);

   bcd_digit_t up_val;
   bcd_digit_t down_val;
   logic       at_max;
   logic       at_min;

   always_comb begin
      at_max     = (digit == BCD_MAX);
      at_min     = (digit == BCD_MIN);
      up_val     = at_max ? BCD_MIN : digit + 4'd1;
      down_val   = at_min ? BCD_MAX : digit - 4'd1;
      carry_out  = inc & carry_in & at_max;
      borrow_out = dec & borrow_in & at_min;
      next       = digit;
      // A digit only moves when every lower digit rolled over.
      if (inc && carry_in) begin
         next = up_val;
      end else if (dec && borrow_in) begin
         next = down_val;
      end
   end

endmodule

// File: rtl/btn_press_counter.sv
// Multi-digit BCD up/down press counter with wrap/saturate limits.
// Optional sticky overflow LED enabled by defining BTN_PRESS_OVF_STICKY_EN.
module btn_press_counter
   import btn_press_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter bit WRAP       = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inc_pulse,
   input  logic                        dec_pulse,
   input  logic                        clr,
   output logic [BCD_W*NUM_DIGITS-1:0] bcd_out,
   output logic                        limit_pulse,
   output logic                        ovf_led
);

   logic [BCD_W*NUM_DIGITS-1:0] next_count;
   logic [NUM_DIGITS:0]         carry;
   logic [NUM_DIGITS:0]         borrow;
   logic                        inc_only;
   logic                        dec_only;
   logic                        limit_hit;

   assign inc_only  = inc_pulse & ~dec_pulse;
   assign dec_only  = dec_pulse & ~inc_pulse;
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
         .digit     (bcd_out[BCD_W*k +: BCD_W]),
         .inc       (inc_only),
         .dec       (dec_only),
         .carry_in  (carry[k]),
         .borrow_in (borrow[k]),
         .next      (next_count[BCD_W*k +: BCD_W]),
         .carry_out (carry[k+1]),
         .borrow_out(borrow[k+1])
      );
   end

   // Carry/borrow out of the top digit means the count was at all-9s / all-0s.
   assign limit_hit = carry[NUM_DIGITS] | borrow[NUM_DIGITS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd_out     <= '0;
         limit_pulse <= 1'b0;
      end else if (clr) begin
         bcd_out     <= '0;
         limit_pulse <= 1'b0;
      end else begin
         limit_pulse <= limit_hit;
         // The ripple chain already yields the wrapped value; saturation just holds.
         if (!limit_hit || WRAP) begin
            bcd_out <= next_count;
         end
      end
   end

`ifdef BTN_PRESS_OVF_STICKY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_led <= 1'b0;
      end else if (clr) begin
         ovf_led <= 1'b0;
      end else if (limit_hit) begin
         ovf_led <= 1'b1;
      end
   end
`else
   assign ovf_led = 1'b0;
`endif

endmodule
